// File: rtl/dcache_mshr_controller.sv
// Non-blocking data-cache controller: tracks outstanding misses by memory tag,
// runs writeback-then-fill for dirty victims and installs returned blocks.
package dcache_mshr_pkg;
  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FILL
  } fsm_e;

  typedef enum logic {
    M_ALLOC,
    M_WAIT
  } mshr_st_e;
endpackage

module dcache_mshr_controller
  import dcache_mshr_pkg::*;
#(
  parameter int NUM_MSHR  = 4,
  parameter int ADDR_W    = 64,
  parameter int BLOCK_W   = 64,
  parameter int OFFSET_W  = 3,
  parameter int INDEX_W   = 5,
  parameter int MEM_TAG_W = 4,
  parameter int ID_W      = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_valid,
  input  BUS_COMMAND                   req_cmd,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [BLOCK_W-1:0]           req_data,
  input  logic [ID_W-1:0]              req_id,
  output logic                         req_ready,
  input  logic                         cache_hit,
  input  logic [BLOCK_W-1:0]           cache_data,
  input  logic                         victim_dirty,
  input  logic [ADDR_W-1:0]            victim_addr,
  input  logic [BLOCK_W-1:0]           victim_data,
  output logic                         cache_wr_en,
  output logic [ADDR_W-1:0]            cache_wr_addr,
  output logic [BLOCK_W-1:0]           cache_wr_data,
  output logic                         cache_wr_dirty,
  output BUS_COMMAND                   proc2Dmem_command,
  output logic [ADDR_W-1:0]            proc2Dmem_addr,
  output logic [BLOCK_W-1:0]           proc2Dmem_data,
  input  logic [MEM_TAG_W-1:0]         Dmem2proc_response,
  input  logic [MEM_TAG_W-1:0]         Dmem2proc_tag,
  input  logic [BLOCK_W-1:0]           Dmem2proc_data,
  output logic                         resp_valid,
  output logic [ID_W-1:0]              resp_id,
  output logic [BLOCK_W-1:0]           resp_data,
  output logic                         resp_is_store,
  output logic [$clog2(NUM_MSHR+1)-1:0] mshr_count
);

  localparam int IDX_W = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;
  localparam int CNT_W = $clog2(NUM_MSHR + 1);
  localparam int SET_HI = OFFSET_W + INDEX_W - 1;
  localparam logic [ADDR_W-1:0] ALIGN =
    ~(ADDR_W'((64'd1 << OFFSET_W) - 64'd1));

  fsm_e                  fsm_q, fsm_d;
  logic [NUM_MSHR-1:0]   vld_q, vld_d;
  logic [NUM_MSHR-1:0]   str_q, str_d;
  mshr_st_e              st_q   [NUM_MSHR];
  mshr_st_e              st_d   [NUM_MSHR];
  logic [ADDR_W-1:0]     addr_q [NUM_MSHR];
  logic [ADDR_W-1:0]     addr_d [NUM_MSHR];
  logic [BLOCK_W-1:0]    data_q [NUM_MSHR];
  logic [BLOCK_W-1:0]    data_d [NUM_MSHR];
  logic [ID_W-1:0]       id_q   [NUM_MSHR];
  logic [ID_W-1:0]       id_d   [NUM_MSHR];
  logic [MEM_TAG_W-1:0]  tag_q  [NUM_MSHR];
  logic [MEM_TAG_W-1:0]  tag_d  [NUM_MSHR];
  logic [IDX_W-1:0]      cur_q, cur_d;
  logic [ADDR_W-1:0]     vaddr_q, vaddr_d;
  logic [BLOCK_W-1:0]    vdata_q, vdata_d;

  logic                  rvld_q, rvld_d;
  logic [ID_W-1:0]       rid_q, rid_d;
  logic [BLOCK_W-1:0]    rdata_q, rdata_d;
  logic                  rstr_q, rstr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  ret_hit;
  logic [IDX_W-1:0]      ret_idx;
  logic                  free_ok;
  logic [IDX_W-1:0]      free_idx;
  logic                  conflict;
  logic                  accept;
  logic                  miss_acc;

  // Descending scan so the lowest free index wins.
  always_comb begin
    ret_hit  = 1'b0;
    ret_idx  = '0;
    free_ok  = 1'b0;
    free_idx = '0;
    conflict = 1'b0;
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      if (vld_q[i] && st_q[i] == M_WAIT &&
          Dmem2proc_tag != '0 && tag_q[i] == Dmem2proc_tag) begin
        ret_hit = 1'b1;
        ret_idx = IDX_W'(i);
      end
      if (!vld_q[i]) begin
        free_ok  = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (vld_q[i] &&
          addr_q[i][SET_HI:OFFSET_W] == req_addr[SET_HI:OFFSET_W]) begin
        conflict = 1'b1;
      end
    end
  end

  assign req_ready = (fsm_q == S_IDLE) && !ret_hit &&
                     (cache_hit || (free_ok && !conflict));
  assign accept    = req_valid && req_ready;
  assign miss_acc  = accept && !cache_hit;

  always_comb begin
    fsm_d   = fsm_q;
    vld_d   = vld_q;
    str_d   = str_q;
    st_d    = st_q;
    addr_d  = addr_q;
    data_d  = data_q;
    id_d    = id_q;
    tag_d   = tag_q;
    cur_d   = cur_q;
    vaddr_d = vaddr_q;
    vdata_d = vdata_q;
    rvld_d  = 1'b0;
    rid_d   = rid_q;
    rdata_d = rdata_q;
    rstr_d  = rstr_q;
    cache_wr_en       = 1'b0;
    cache_wr_addr     = '0;
    cache_wr_data     = '0;
    cache_wr_dirty    = 1'b0;
    proc2Dmem_command = BUS_NONE;
    proc2Dmem_addr    = '0;
    proc2Dmem_data    = '0;

    unique case (fsm_q)
      S_IDLE: begin
        if (miss_acc) begin
          vld_d[free_idx]  = 1'b1;
          str_d[free_idx]  = (req_cmd == BUS_STORE);
          st_d[free_idx]   = M_ALLOC;
          addr_d[free_idx] = req_addr;
          data_d[free_idx] = req_data;
          id_d[free_idx]   = req_id;
          tag_d[free_idx]  = '0;
          cur_d   = free_idx;
          vaddr_d = victim_addr;
          vdata_d = victim_data;
          fsm_d   = victim_dirty ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        proc2Dmem_command = BUS_STORE;
        proc2Dmem_addr    = vaddr_q & ALIGN;
        proc2Dmem_data    = vdata_q;
        if (Dmem2proc_response != '0) fsm_d = S_FILL;
      end
      S_FILL: begin
        proc2Dmem_command = BUS_LOAD;
        proc2Dmem_addr    = addr_q[cur_q] & ALIGN;
        if (Dmem2proc_response != '0) begin
          tag_d[cur_q] = Dmem2proc_response;
          st_d[cur_q]  = M_WAIT;
          fsm_d        = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase

    // A return owns the write port and response register; hits are stalled.
    if (ret_hit) begin
      cache_wr_en    = 1'b1;
      cache_wr_addr  = addr_q[ret_idx] & ALIGN;
      cache_wr_data  = str_q[ret_idx] ? data_q[ret_idx] : Dmem2proc_data;
      cache_wr_dirty = str_q[ret_idx];
      rvld_d         = 1'b1;
      rid_d          = id_q[ret_idx];
      rdata_d        = cache_wr_data;
      rstr_d         = str_q[ret_idx];
      vld_d[ret_idx] = 1'b0;
    end else if (accept && cache_hit) begin
      rvld_d = 1'b1;
      rid_d  = req_id;
      if (req_cmd == BUS_STORE) begin
        cache_wr_en    = 1'b1;
        cache_wr_addr  = req_addr & ALIGN;
        cache_wr_data  = req_data;
        cache_wr_dirty = 1'b1;
        rdata_d        = req_data;
        rstr_d         = 1'b1;
      end else begin
        rdata_d = cache_data;
        rstr_d  = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NUM_MSHR; i++) begin
      cnt_d = cnt_d + CNT_W'(vld_d[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q   <= S_IDLE;
      vld_q   <= '0;
      cur_q   <= '0;
      rvld_q  <= 1'b0;
      rid_q   <= '0;
      rdata_q <= '0;
      rstr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      vld_q   <= vld_d;
      cur_q   <= cur_d;
      rvld_q  <= rvld_d;
      rid_q   <= rid_d;
      rdata_q <= rdata_d;
      rstr_q  <= rstr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Payload is qualified by vld_q, so it needs no reset.
  always_ff @(posedge clock) begin
    str_q   <= str_d;
    st_q    <= st_d;
    addr_q  <= addr_d;
    data_q  <= data_d;
    id_q    <= id_d;
    tag_q   <= tag_d;
    vaddr_q <= vaddr_d;
    vdata_q <= vdata_d;
  end

  assign resp_valid    = rvld_q;
  assign resp_id       = rid_q;
  assign resp_data     = rdata_q;
  assign resp_is_store = rstr_q;
  assign mshr_count    = cnt_q;

endmodule

// File: tb/tb_dcache_mshr_controller.sv
// Directed bench for dcache_mshr_controller: hits, clean/dirty misses,
// MSHR-full and set-conflict stalls, and reset during writeback.
module tb_dcache_mshr_controller;
  import dcache_mshr_pkg::*;

  logic        clock;
  logic        reset;
  logic        req_valid;
  BUS_COMMAND  req_cmd;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic [3:0]  req_id;
  logic        req_ready;
  logic        cache_hit;
  logic [63:0] cache_data;
  logic        victim_dirty;
  logic [63:0] victim_addr;
  logic [63:0] victim_data;
  logic        cache_wr_en;
  logic [63:0] cache_wr_addr;
  logic [63:0] cache_wr_data;
  logic        cache_wr_dirty;
  BUS_COMMAND  proc2Dmem_command;
  logic [63:0] proc2Dmem_addr;
  logic [63:0] proc2Dmem_data;
  logic [3:0]  Dmem2proc_response;
  logic [3:0]  Dmem2proc_tag;
  logic [63:0] Dmem2proc_data;
  logic        resp_valid;
  logic [3:0]  resp_id;
  logic [63:0] resp_data;
  logic        resp_is_store;
  logic [2:0]  mshr_count;

  int vectors = 0;
  int miscompares = 0;

  dcache_mshr_controller dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_data(req_data), .req_id(req_id), .req_ready(req_ready),
    .cache_hit(cache_hit), .cache_data(cache_data),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr),
    .victim_data(victim_data),
    .cache_wr_en(cache_wr_en), .cache_wr_addr(cache_wr_addr),
    .cache_wr_data(cache_wr_data), .cache_wr_dirty(cache_wr_dirty),
    .proc2Dmem_command(proc2Dmem_command), .proc2Dmem_addr(proc2Dmem_addr),
    .proc2Dmem_data(proc2Dmem_data),
    .Dmem2proc_response(Dmem2proc_response), .Dmem2proc_tag(Dmem2proc_tag),
    .Dmem2proc_data(Dmem2proc_data),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_is_store(resp_is_store), .mshr_count(mshr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_cmd = BUS_LOAD; req_addr = '0; req_data = '0;
    req_id = '0; cache_hit = 0; cache_data = '0; victim_dirty = 0;
    victim_addr = '0; victim_data = '0; Dmem2proc_response = '0;
    Dmem2proc_tag = '0; Dmem2proc_data = '0;
  endtask

  task automatic drive_req(input BUS_COMMAND c, input logic [63:0] a,
                           input logic [63:0] d, input logic [3:0] id,
                           input logic hit);
    req_valid = 1; req_cmd = c; req_addr = a; req_data = d;
    req_id = id; cache_hit = hit;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    vectors++;
    if (resp_valid !== 1'b0 || mshr_count !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_state resp_valid=%0b cnt=%0d exp 0/0", resp_valid, mshr_count);
    end
    vectors++;
    if (proc2Dmem_command !== BUS_NONE || proc2Dmem_addr !== 64'h0 ||
        cache_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_bus cmd=%0d addr=%h wr=%0b exp 0/0/0",
               proc2Dmem_command, proc2Dmem_addr, cache_wr_en);
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready got=%0b exp=1", req_ready);
    end
  endtask

  task automatic test_load_hit();
    drive_req(BUS_LOAD, 64'h100, 64'h0, 4'd3, 1'b1);
    cache_data = 64'hAA;
    #1;
    vectors++;
    if (req_ready !== 1'b1 || proc2Dmem_command !== BUS_NONE) begin
      miscompares++;
      $display("FAIL ld_hit_ready ready=%0b cmd=%0d exp 1/0", req_ready, proc2Dmem_command);
    end
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (resp_valid !== 1'b1 || resp_id !== 4'd3 ||
        resp_data !== 64'hAA || resp_is_store !== 1'b0) begin
      miscompares++;
      $display("FAIL ld_hit_resp v=%0b id=%0d d=%h st=%0b exp 1/3/aa/0",
               resp_valid, resp_id, resp_data, resp_is_store);
    end
    tick();
    vectors++;
    if (resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ld_hit_pulse got=%0b exp=0", resp_valid);
    end
  endtask

  task automatic test_store_hit();
    drive_req(BUS_STORE, 64'h10D, 64'hBEEF, 4'd7, 1'b1);
    #1;
    vectors++;
    if (cache_wr_en !== 1'b1 || cache_wr_addr !== 64'h108 ||
        cache_wr_data !== 64'hBEEF || cache_wr_dirty !== 1'b1) begin
      miscompares++;
      $display("FAIL st_hit_wr en=%0b a=%h d=%h dirty=%0b exp 1/108/beef/1",
               cache_wr_en, cache_wr_addr, cache_wr_data, cache_wr_dirty);
    end
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (resp_valid !== 1'b1 || resp_id !== 4'd7 || resp_is_store !== 1'b1) begin
      miscompares++;
      $display("FAIL st_hit_ack v=%0b id=%0d st=%0b exp 1/7/1", resp_valid, resp_id, resp_is_store);
    end
    tick();
  endtask

  task automatic test_clean_miss();
    logic [3:0] rsp [3];
    int loads;
    rsp[0] = 4'd0; rsp[1] = 4'd0; rsp[2] = 4'd5;
    loads = 0;
    drive_req(BUS_LOAD, 64'h208, 64'h0, 4'd1, 1'b0);
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL miss_ready got=%0b exp=1", req_ready);
    end
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      Dmem2proc_response = rsp[c];
      #1;
      if (proc2Dmem_command == BUS_LOAD && proc2Dmem_addr == 64'h208) loads++;
      tick();
    end
    Dmem2proc_response = '0;
    vectors++;
    if (loads !== 3) begin
      miscompares++;
      $display("FAIL miss_load_cycles got=%0d exp=3", loads);
    end
    vectors++;
    if (proc2Dmem_command !== BUS_NONE || mshr_count !== 3'd1) begin
      miscompares++;
      $display("FAIL miss_wait cmd=%0d cnt=%0d exp 0/1", proc2Dmem_command, mshr_count);
    end
    Dmem2proc_tag = 4'd5;
    Dmem2proc_data = 64'h55;
    #1;
    vectors++;
    if (cache_wr_en !== 1'b1 || cache_wr_addr !== 64'h208 ||
        cache_wr_data !== 64'h55 || cache_wr_dirty !== 1'b0) begin
      miscompares++;
      $display("FAIL miss_install en=%0b a=%h d=%h dirty=%0b exp 1/208/55/0",
               cache_wr_en, cache_wr_addr, cache_wr_data, cache_wr_dirty);
    end
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (resp_valid !== 1'b1 || resp_id !== 4'd1 || resp_data !== 64'h55 ||
        resp_is_store !== 1'b0 || mshr_count !== 3'd0) begin
      miscompares++;
      $display("FAIL miss_resp v=%0b id=%0d d=%h st=%0b cnt=%0d exp 1/1/55/0/0",
               resp_valid, resp_id, resp_data, resp_is_store, mshr_count);
    end
    tick();
  endtask

  task automatic test_dirty_store_miss();
    drive_req(BUS_STORE, 64'h300, 64'h77, 4'd6, 1'b0);
    victim_dirty = 1; victim_addr = 64'h700; victim_data = 64'h11;
    tick();
    idle_inputs();
    victim_addr = 64'hFFF8; victim_data = 64'hDEAD;
    #1;
    vectors++;
    if (proc2Dmem_command !== BUS_STORE || proc2Dmem_addr !== 64'h700 ||
        proc2Dmem_data !== 64'h11) begin
      miscompares++;
      $display("FAIL wb_issue cmd=%0d a=%h d=%h exp 2/700/11",
               proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data);
    end
    tick();
    vectors++;
    if (proc2Dmem_command !== BUS_STORE) begin
      miscompares++;
      $display("FAIL wb_retry cmd=%0d exp=2", proc2Dmem_command);
    end
    Dmem2proc_response = 4'd2;
    tick();
    Dmem2proc_response = '0;
    #1;
    vectors++;
    if (proc2Dmem_command !== BUS_LOAD || proc2Dmem_addr !== 64'h300) begin
      miscompares++;
      $display("FAIL wb_fill cmd=%0d a=%h exp 1/300", proc2Dmem_command, proc2Dmem_addr);
    end
    Dmem2proc_response = 4'd7;
    tick();
    Dmem2proc_response = '0;
    Dmem2proc_tag = 4'd7;
    Dmem2proc_data = 64'h99;
    #1;
    vectors++;
    if (cache_wr_en !== 1'b1 || cache_wr_addr !== 64'h300 ||
        cache_wr_data !== 64'h77 || cache_wr_dirty !== 1'b1) begin
      miscompares++;
      $display("FAIL st_miss_install en=%0b a=%h d=%h dirty=%0b exp 1/300/77/1",
               cache_wr_en, cache_wr_addr, cache_wr_data, cache_wr_dirty);
    end
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (resp_valid !== 1'b1 || resp_is_store !== 1'b1 ||
        resp_id !== 4'd6 || resp_data !== 64'h77) begin
      miscompares++;
      $display("FAIL st_miss_ack v=%0b st=%0b id=%0d d=%h exp 1/1/6/77",
               resp_valid, resp_is_store, resp_id, resp_data);
    end
    tick();
  endtask

  task automatic test_mshr_full();
    logic [3:0] drain [4];
    drain[0] = 4'd1; drain[1] = 4'd3; drain[2] = 4'd4; drain[3] = 4'd5;
    for (int k = 0; k < 4; k++) begin
      drive_req(BUS_LOAD, 64'(8 * (k + 1)), 64'h0, 4'(k), 1'b0);
      tick();
      idle_inputs();
      Dmem2proc_response = 4'(k + 1);
      tick();
      Dmem2proc_response = '0;
    end
    vectors++;
    if (mshr_count !== 3'd4) begin
      miscompares++;
      $display("FAIL full_count got=%0d exp=4", mshr_count);
    end
    drive_req(BUS_LOAD, 64'h28, 64'h0, 4'd9, 1'b0);
    #1;
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_miss_stall got=%0b exp=0", req_ready);
    end
    cache_hit = 1; cache_data = 64'h42;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL full_hit_ready got=%0b exp=1", req_ready);
    end
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (resp_valid !== 1'b1 || resp_data !== 64'h42 || mshr_count !== 3'd4) begin
      miscompares++;
      $display("FAIL full_hit_resp v=%0b d=%h cnt=%0d exp 1/42/4", resp_valid, resp_data, mshr_count);
    end
    Dmem2proc_tag = 4'd2; Dmem2proc_data = 64'h22;
    #1;
    vectors++;
    if (cache_wr_en !== 1'b1 || cache_wr_addr !== 64'h10) begin
      miscompares++;
      $display("FAIL full_ret_wr en=%0b a=%h exp 1/10", cache_wr_en, cache_wr_addr);
    end
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (resp_id !== 4'd1 || mshr_count !== 3'd3) begin
      miscompares++;
      $display("FAIL full_ret_resp id=%0d cnt=%0d exp 1/3", resp_id, mshr_count);
    end
    drive_req(BUS_LOAD, 64'h28, 64'h0, 4'd10, 1'b0);
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL full_fifth_ready got=%0b exp=1", req_ready);
    end
    tick();
    idle_inputs();
    Dmem2proc_response = 4'd5;
    tick();
    Dmem2proc_response = '0;
    for (int k = 0; k < 4; k++) begin
      Dmem2proc_tag = drain[k];
      tick();
    end
    idle_inputs();
    #1;
    vectors++;
    if (mshr_count !== 3'd0 || resp_id !== 4'd10) begin
      miscompares++;
      $display("FAIL full_drain cnt=%0d id=%0d exp 0/10", mshr_count, resp_id);
    end
    tick();
  endtask

  task automatic test_set_conflict();
    drive_req(BUS_LOAD, 64'h40, 64'h0, 4'd2, 1'b0);
    tick();
    idle_inputs();
    Dmem2proc_response = 4'd9;
    tick();
    Dmem2proc_response = '0;
    drive_req(BUS_LOAD, 64'h440, 64'h0, 4'd4, 1'b0);
    #1;
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL conflict_stall got=%0b exp=0", req_ready);
    end
    tick();
    Dmem2proc_tag = 4'd9; Dmem2proc_data = 64'h33;
    #1;
    vectors++;
    if (req_ready !== 1'b0 || cache_wr_en !== 1'b1) begin
      miscompares++;
      $display("FAIL conflict_ret ready=%0b wr=%0b exp 0/1", req_ready, cache_wr_en);
    end
    tick();
    Dmem2proc_tag = '0;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL conflict_release got=%0b exp=1", req_ready);
    end
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (proc2Dmem_command !== BUS_LOAD || proc2Dmem_addr !== 64'h440 ||
        mshr_count !== 3'd1) begin
      miscompares++;
      $display("FAIL conflict_fill cmd=%0d a=%h cnt=%0d exp 1/440/1",
               proc2Dmem_command, proc2Dmem_addr, mshr_count);
    end
    Dmem2proc_response = 4'd10;
    tick();
    Dmem2proc_response = '0;
    Dmem2proc_tag = 4'd10;
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (resp_valid !== 1'b1 || resp_id !== 4'd4) begin
      miscompares++;
      $display("FAIL conflict_resp v=%0b id=%0d exp 1/4", resp_valid, resp_id);
    end
    tick();
  endtask

  task automatic test_reset_mid_wb();
    drive_req(BUS_LOAD, 64'h80, 64'h0, 4'd5, 1'b0);
    tick();
    idle_inputs();
    Dmem2proc_response = 4'd11;
    tick();
    Dmem2proc_response = '0;
    drive_req(BUS_STORE, 64'hC0, 64'h1, 4'd8, 1'b0);
    victim_dirty = 1; victim_addr = 64'h8C0; victim_data = 64'h5A;
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (proc2Dmem_command !== BUS_STORE) begin
      miscompares++;
      $display("FAIL rst_wb_pre cmd=%0d exp=2", proc2Dmem_command);
    end
    reset = 1;
    tick();
    reset = 0;
    #1;
    vectors++;
    if (proc2Dmem_command !== BUS_NONE || mshr_count !== 3'd0 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_wb_post cmd=%0d cnt=%0d v=%0b exp 0/0/0",
               proc2Dmem_command, mshr_count, resp_valid);
    end
    Dmem2proc_tag = 4'd11; Dmem2proc_data = 64'h66;
    #1;
    vectors++;
    if (cache_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_stale_wr got=%0b exp=0", cache_wr_en);
    end
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_stale_resp got=%0b exp=0", resp_valid);
    end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_load_hit();
    test_store_hit();
    test_clean_miss();
    test_dirty_store_miss();
    test_mshr_full();
    test_set_conflict();
    test_reset_mid_wb();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
